alu_reservation_station: RTL

- 16-entry reservation station for integer ALU ops in the Tomasulo core.
- Sits between dispatch (decoder/ROB allocation) and the single-cycle ALU.
- Holds operands or ROB tags, wakes up on CDB broadcasts, and issues the lowest-index ready entry each cycle.
- Internally uses the codebase's find_first_ready, find_first_vacant and count_vacancies helpers.

---
 rtl/alu_reservation_station.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_reservation_station.sv
// 16-entry reservation station for the integer ALU: holds operands or ROB tags, wakes on CDB, issues lowest ready entry.
// Optional macro RS_PERF_CNT_EN adds saturating issue / full-while-dispatching counters.
module alu_reservation_station #(
    parameter int ROB_W  = 4,
    parameter int OP_W   = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              disp_valid_in,
    input  logic [OP_W-1:0]   disp_op_in,
    input  logic [DATA_W-1:0] disp_Vj_in,
    input  logic [DATA_W-1:0] disp_Vk_in,
    input  logic [ROB_W-1:0]  disp_Qj_in,
    input  logic [ROB_W-1:0]  disp_Qk_in,
    input  logic [ROB_W-1:0]  disp_dest_in,
    output logic              full_out,
    input  logic              cdb_valid_in,
    input  logic [ROB_W-1:0]  cdb_tag_in,
    input  logic [DATA_W-1:0] cdb_value_in,
    output logic              alu_valid_out,
    output logic [OP_W-1:0]   alu_op_out,
    output logic [DATA_W-1:0] alu_a_out,
    output logic [DATA_W-1:0] alu_b_out,
    output logic [ROB_W-1:0]  alu_dest_out
`ifdef RS_PERF_CNT_EN
    ,
    output logic [31:0]       perf_issue_cnt_out,
    output logic [31:0]       perf_full_cnt_out
`endif
);

    localparam int N     = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;

    // Handshake: full_out low means a dispatch may be presented next cycle (one slot of slack for
    // an in-flight dispatch); alu_valid_out is a one-cycle pulse per issue with no back-pressure.

    function automatic logic [IDX_W:0] find_first_ready(input logic [N-1:0] ready_vec);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ready_vec[i]) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    function automatic logic [IDX_W:0] find_first_vacant(input logic [N-1:0] busy_vec);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy_vec[i]) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] count_vacancies(input logic [N-1:0] busy_vec);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + CNT_W'(!busy_vec[i]);
        end
        return c;
    endfunction

    logic [N-1:0]      busy_q;
    logic [OP_W-1:0]   op_q   [N];
    logic [DATA_W-1:0] vj_q   [N];
    logic [DATA_W-1:0] vk_q   [N];
    logic [ROB_W-1:0]  qj_q   [N];
    logic [ROB_W-1:0]  qk_q   [N];
    logic [ROB_W-1:0]  dest_q [N];

    logic [N-1:0]      ready_vec;
    logic              issue_found;
    logic [IDX_W-1:0]  issue_idx;
    logic              disp_found;
    logic [IDX_W-1:0]  disp_idx;
    logic [CNT_W-1:0]  vac_cnt;
    logic              cdb_hit;
    logic              disp_qj_hit;
    logic              disp_qk_hit;

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < N; i++) begin
            ready_vec[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        end
    end

    assign {issue_found, issue_idx} = find_first_ready(ready_vec);
    assign {disp_found, disp_idx}   = find_first_vacant(busy_q);
    assign vac_cnt                  = count_vacancies(busy_q);
    assign full_out                 = (vac_cnt <= CNT_W'(1));

    // Tag 0 means "value valid", so a broadcast of tag 0 must never match anything.
    assign cdb_hit     = cdb_valid_in && (cdb_tag_in != '0);
    assign disp_qj_hit = cdb_hit && (disp_Qj_in == cdb_tag_in);
    assign disp_qk_hit = cdb_hit && (disp_Qk_in == cdb_tag_in);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q        <= '0;
            alu_valid_out <= 1'b0;
            alu_op_out    <= '0;
            alu_a_out     <= '0;
            alu_b_out     <= '0;
            alu_dest_out  <= '0;
            for (int i = 0; i < N; i++) begin
                op_q[i]   <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                dest_q[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                busy_q        <= '0;
                alu_valid_out <= 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (cdb_hit && busy_q[i] && (qj_q[i] == cdb_tag_in)) begin
                        vj_q[i] <= cdb_value_in;
                        qj_q[i] <= '0;
                    end
                    if (cdb_hit && busy_q[i] && (qk_q[i] == cdb_tag_in)) begin
                        vk_q[i] <= cdb_value_in;
                        qk_q[i] <= '0;
                    end
                end

                if (issue_found) begin
                    alu_valid_out     <= 1'b1;
                    alu_op_out        <= op_q[issue_idx];
                    alu_a_out         <= vj_q[issue_idx];
                    alu_b_out         <= vk_q[issue_idx];
                    alu_dest_out      <= dest_q[issue_idx];
                    busy_q[issue_idx] <= 1'b0;
                end else begin
                    alu_valid_out <= 1'b0;
                end

                // The issuing slot is still busy pre-edge, so dispatch can never land on it.
                if (disp_valid_in && disp_found) begin
                    busy_q[disp_idx] <= 1'b1;
                    op_q[disp_idx]   <= disp_op_in;
                    dest_q[disp_idx] <= disp_dest_in;
                    vj_q[disp_idx]   <= disp_qj_hit ? cdb_value_in : disp_Vj_in;
                    qj_q[disp_idx]   <= disp_qj_hit ? '0 : disp_Qj_in;
                    vk_q[disp_idx]   <= disp_qk_hit ? cdb_value_in : disp_Vk_in;
                    qk_q[disp_idx]   <= disp_qk_hit ? '0 : disp_Qk_in;
                end
            end
        end
    end

`ifdef RS_PERF_CNT_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            perf_issue_cnt_out <= '0;
            perf_full_cnt_out  <= '0;
        end else if (rdy_in) begin
            if (!flush_in && issue_found && (perf_issue_cnt_out != '1))
                perf_issue_cnt_out <= perf_issue_cnt_out + 32'd1;
            if (full_out && disp_valid_in && (perf_full_cnt_out != '1))
                perf_full_cnt_out <= perf_full_cnt_out + 32'd1;
        end
    end
`endif

    disp_overflow_a: assert property (@(posedge clk_in) disable iff (!rst_in)
        (rdy_in && !flush_in && disp_valid_in) |-> (vac_cnt != '0));

endmodule
